// File: rtl/periph_axi_reg_bridge.sv
// AXI4 (64-bit) to 32-bit register-interface bridge for the peripheral demux.
// One transaction at a time, round-robin read/write arbitration, SLVERR for bursts and 8-byte accesses.

package core_v_mcu_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_slv_rsp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module periph_axi_reg_bridge #(
  parameter type axi_req_t = core_v_mcu_pkg::axi_slv_req_t,
  parameter type axi_rsp_t = core_v_mcu_pkg::axi_slv_rsp_t,
  parameter type reg_req_t = core_v_mcu_pkg::reg_req_t,
  parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i
);

  localparam int unsigned IdW   = $bits(axi_req_i.aw.id);
  localparam int unsigned AddrW = $bits(axi_req_i.aw.addr);
  localparam int unsigned LenW  = $bits(axi_req_i.ar.len);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_DRAIN, REG_WR, REG_RD, B_RESP, R_RESP, R_ERR
  } state_e;

  state_e             state_r, state_s;
  logic               prio_r;  // 0: write wins a tie, 1: read wins
  logic [IdW-1:0]     id_r;
  logic [AddrW-1:0]   addr_r;
  logic [31:0]        wdata_r;
  logic [3:0]         wstrb_r;
  logic [1:0]         resp_r;
  logic [31:0]        rdata_r;
  logic [LenW-1:0]    beat_r;
  logic [31:0]        tmo_cnt_r;

  logic wr_grant_s, rd_grant_s, wr_ok_s, rd_ok_s;
  logic reg_busy_s, tmo_s, r_err_adv_s;

  // Arbitration, next-state and output decode; outputs depend only on state registers except IDLE readies.
  always_comb begin
    state_s     = state_r;
    wr_grant_s  = 1'b0;
    rd_grant_s  = 1'b0;
    reg_busy_s  = 1'b0;
    r_err_adv_s = 1'b0;
    axi_rsp_o   = '0;
    reg_req_o   = '0;

    wr_ok_s = (axi_req_i.aw.len == '0) && (axi_req_i.aw.size < 3'd3);
    rd_ok_s = (axi_req_i.ar.len == '0) && (axi_req_i.ar.size < 3'd3);

    if ((TimeoutCycles != 32'd0) && !reg_rsp_i.ready &&
        (tmo_cnt_r == 32'(TimeoutCycles - 32'd1))) begin
      tmo_s = 1'b1;
    end else begin
      tmo_s = 1'b0;
    end

    axi_rsp_o.b.id   = id_r;
    axi_rsp_o.b.resp = resp_r;
    axi_rsp_o.r.id   = id_r;
    axi_rsp_o.r.resp = resp_r;
    reg_req_o.addr   = addr_r;
    reg_req_o.wdata  = wdata_r;
    reg_req_o.wstrb  = wstrb_r;

    case (state_r)
      IDLE: begin
        if (axi_req_i.aw_valid && axi_req_i.w_valid && (!axi_req_i.ar_valid || !prio_r)) begin
          wr_grant_s         = 1'b1;
          axi_rsp_o.aw_ready = 1'b1;
          axi_rsp_o.w_ready  = 1'b1;
          if (wr_ok_s) begin
            state_s = REG_WR;
          end else if ((axi_req_i.aw.len != '0) && !axi_req_i.w.last) begin
            state_s = WR_DRAIN;
          end else begin
            state_s = B_RESP;
          end
        end else if (axi_req_i.ar_valid) begin
          rd_grant_s         = 1'b1;
          axi_rsp_o.ar_ready = 1'b1;
          state_s            = rd_ok_s ? REG_RD : R_ERR;
        end else begin
          state_s = IDLE;
        end
      end
      WR_DRAIN: begin
        axi_rsp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid && axi_req_i.w.last) begin
          state_s = B_RESP;
        end else begin
          state_s = WR_DRAIN;
        end
      end
      REG_WR, REG_RD: begin
        reg_busy_s      = 1'b1;
        reg_req_o.valid = 1'b1;
        reg_req_o.write = (state_r == REG_WR);
        if (reg_rsp_i.ready || tmo_s) begin
          state_s = (state_r == REG_WR) ? B_RESP : R_RESP;
        end else begin
          state_s = state_r;
        end
      end
      B_RESP: begin
        axi_rsp_o.b_valid = 1'b1;
        state_s = axi_req_i.b_ready ? IDLE : B_RESP;
      end
      R_RESP: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.last  = 1'b1;
        axi_rsp_o.r.data  = {rdata_r, rdata_r};
        state_s = axi_req_i.r_ready ? IDLE : R_RESP;
      end
      R_ERR: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.last  = (beat_r == '0);
        if (axi_req_i.r_ready && (beat_r == '0)) begin
          state_s = IDLE;
        end else if (axi_req_i.r_ready) begin
          r_err_adv_s = 1'b1;
        end else begin
          state_s = R_ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched transaction fields, priority bit and timeout counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      prio_r    <= 1'b0;
      id_r      <= '0;
      addr_r    <= '0;
      wdata_r   <= 32'h0;
      wstrb_r   <= 4'h0;
      resp_r    <= RESP_OKAY;
      rdata_r   <= 32'h0;
      beat_r    <= '0;
      tmo_cnt_r <= 32'd0;
    end else begin
      state_r <= state_s;
      if (wr_grant_s) begin
        id_r      <= axi_req_i.aw.id;
        addr_r    <= axi_req_i.aw.addr;
        wdata_r   <= axi_req_i.aw.addr[2] ? axi_req_i.w.data[63:32] : axi_req_i.w.data[31:0];
        wstrb_r   <= axi_req_i.aw.addr[2] ? axi_req_i.w.strb[7:4] : axi_req_i.w.strb[3:0];
        resp_r    <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        prio_r    <= ~prio_r;
        tmo_cnt_r <= 32'd0;
      end else if (rd_grant_s) begin
        id_r      <= axi_req_i.ar.id;
        addr_r    <= axi_req_i.ar.addr;
        beat_r    <= axi_req_i.ar.len;
        resp_r    <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
        rdata_r   <= 32'h0;
        prio_r    <= ~prio_r;
        tmo_cnt_r <= 32'd0;
      end else if (reg_busy_s) begin
        // ready takes precedence over a timeout landing in the same cycle
        if (reg_rsp_i.ready) begin
          resp_r  <= reg_rsp_i.error ? RESP_SLVERR : RESP_OKAY;
          rdata_r <= reg_rsp_i.rdata;
        end else if (tmo_s) begin
          resp_r  <= RESP_SLVERR;
          rdata_r <= 32'h0;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
      end else if (r_err_adv_s) begin
        beat_r <= beat_r - {{(LenW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_periph_axi_reg_bridge.sv
// Directed bench for periph_axi_reg_bridge: lane select, arbitration, burst rejection, timeout, reset abort.

module tb_periph_axi_reg_bridge;
  import core_v_mcu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  axi_slv_req_t req;
  axi_slv_rsp_t rsp;
  reg_req_t     rreq;
  reg_rsp_t     rrsp;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  periph_axi_reg_bridge #(.TimeoutCycles(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .axi_req_i (req),
    .axi_rsp_o (rsp),
    .reg_req_o (rreq),
    .reg_rsp_i (rrsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
    req.aw.id   = id;
    req.aw.addr = addr;
    req.aw.len  = len;
    req.aw.size = size;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size);
    req.ar.id   = id;
    req.ar.addr = addr;
    req.ar.len  = len;
    req.ar.size = size;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    rrsp = '0;
    repeat (3) cyc();
    smp();
    chk("rst_b_valid", 64'(rsp.b_valid), 64'd0);
    chk("rst_r_valid", 64'(rsp.r_valid), 64'd0);
    chk("rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
    chk("rst_reg_valid", 64'(rreq.valid), 64'd0);
    chk("rst_reg_addr", rreq.addr, 64'd0);
    cyc();
    rst = 1'b0;

    // single write, upper lane, zero-wait slave
    cyc();
    set_aw(4'd3, 64'h1000_1000_0000_0004, 8'd0, 3'd2);
    req.aw_valid = 1'b1;
    req.w.data = 64'hAABBCCDD_11223344; req.w.strb = 8'hF0; req.w.last = 1'b1; req.w_valid = 1'b1;
    rrsp.ready = 1'b1; rrsp.error = 1'b0; rrsp.rdata = 32'h0;
    smp();
    chk("wr1_aw_ready", 64'(rsp.aw_ready), 64'd1);
    chk("wr1_w_ready", 64'(rsp.w_ready), 64'd1);
    chk("wr1_c0_reg_valid", 64'(rreq.valid), 64'd0);
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    smp();
    chk("wr1_reg_valid", 64'(rreq.valid), 64'd1);
    chk("wr1_reg_write", 64'(rreq.write), 64'd1);
    chk("wr1_reg_wdata", 64'(rreq.wdata), 64'hAABBCCDD);
    chk("wr1_reg_wstrb", 64'(rreq.wstrb), 64'hF);
    chk("wr1_reg_addr", rreq.addr, 64'h1000_1000_0000_0004);
    chk("wr1_c1_b_valid", 64'(rsp.b_valid), 64'd0);
    cyc(); smp();
    chk("wr1_b_valid", 64'(rsp.b_valid), 64'd1);
    chk("wr1_b_id", 64'(rsp.b.id), 64'd3);
    chk("wr1_b_resp", 64'(rsp.b.resp), 64'd0);
    chk("wr1_b_user", 64'(rsp.b.user), 64'd0);
    chk("wr1_c2_reg_valid", 64'(rreq.valid), 64'd0);
    cyc();
    req.b_ready = 1'b1;
    smp();
    chk("wr1_b_hold", 64'(rsp.b_valid), 64'd1);
    chk("wr1_b_hold_id", 64'(rsp.b.id), 64'd3);
    cyc();
    req.b_ready = 1'b0;
    smp();
    chk("wr1_b_done", 64'(rsp.b_valid), 64'd0);

    // single read, error slave
    cyc();
    set_ar(4'd5, 64'h1000_3000_0000_0000, 8'd0, 3'd2);
    req.ar_valid = 1'b1; req.r_ready = 1'b1;
    rrsp.ready = 1'b1; rrsp.error = 1'b1; rrsp.rdata = 32'h12345678;
    smp();
    chk("rd1_ar_ready", 64'(rsp.ar_ready), 64'd1);
    cyc();
    req.ar_valid = 1'b0;
    smp();
    chk("rd1_reg_valid", 64'(rreq.valid), 64'd1);
    chk("rd1_reg_write", 64'(rreq.write), 64'd0);
    chk("rd1_reg_addr", rreq.addr, 64'h1000_3000_0000_0000);
    cyc(); smp();
    chk("rd1_r_valid", 64'(rsp.r_valid), 64'd1);
    chk("rd1_r_data", rsp.r.data, 64'h12345678_12345678);
    chk("rd1_r_resp", 64'(rsp.r.resp), 64'd2);
    chk("rd1_r_last", 64'(rsp.r.last), 64'd1);
    chk("rd1_r_id", 64'(rsp.r.id), 64'd5);
    chk("rd1_r_user", 64'(rsp.r.user), 64'd0);
    cyc(); smp();
    chk("rd1_r_done", 64'(rsp.r_valid), 64'd0);

    // simultaneous eligibility twice: write first, then read; lower lane write
    cyc();
    rrsp.error = 1'b0; rrsp.rdata = 32'hCAFEF00D; req.b_ready = 1'b1;
    set_aw(4'd1, 64'h0, 8'd0, 3'd2);
    req.aw_valid = 1'b1;
    req.w.data = 64'h55667788_99AABBCC; req.w.strb = 8'h0F; req.w.last = 1'b1; req.w_valid = 1'b1;
    set_ar(4'd9, 64'h1000_2000_0000_0008, 8'd0, 3'd2);
    req.ar_valid = 1'b1;
    smp();
    chk("arb1_aw_ready", 64'(rsp.aw_ready), 64'd1);
    chk("arb1_ar_ready", 64'(rsp.ar_ready), 64'd0);
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    smp();
    chk("arb1_reg_write", 64'(rreq.write), 64'd1);
    chk("arb1_reg_wdata", 64'(rreq.wdata), 64'h99AABBCC);
    chk("arb1_reg_wstrb", 64'(rreq.wstrb), 64'hF);
    chk("arb1_busy_ar_ready", 64'(rsp.ar_ready), 64'd0);
    cyc(); smp();
    chk("arb1_b_valid", 64'(rsp.b_valid), 64'd1);
    chk("arb1_b_id", 64'(rsp.b.id), 64'd1);
    cyc();
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    smp();
    chk("arb2_ar_ready", 64'(rsp.ar_ready), 64'd1);
    chk("arb2_aw_ready", 64'(rsp.aw_ready), 64'd0);
    chk("arb2_w_ready", 64'(rsp.w_ready), 64'd0);
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    smp();
    chk("arb2_reg_write", 64'(rreq.write), 64'd0);
    chk("arb2_reg_addr", rreq.addr, 64'h1000_2000_0000_0008);
    cyc(); smp();
    chk("arb2_r_data", rsp.r.data, 64'hCAFEF00D_CAFEF00D);
    chk("arb2_r_resp", 64'(rsp.r.resp), 64'd0);
    chk("arb2_r_id", 64'(rsp.r.id), 64'd9);
    cyc(); smp();
    chk("arb2_r_done", 64'(rsp.r_valid), 64'd0);

    // write burst len 3: drained, one SLVERR, no register access
    cyc();
    req.b_ready = 1'b0;
    set_aw(4'd2, 64'h20, 8'd3, 3'd2);
    req.aw_valid = 1'b1; req.w.last = 1'b0; req.w_valid = 1'b1;
    smp();
    chk("wb_aw_ready", 64'(rsp.aw_ready), 64'd1);
    chk("wb_w_ready", 64'(rsp.w_ready), 64'd1);
    cyc();
    req.aw_valid = 1'b0;
    smp();
    chk("wb_beat2_w_ready", 64'(rsp.w_ready), 64'd1);
    chk("wb_beat2_aw_ready", 64'(rsp.aw_ready), 64'd0);
    chk("wb_beat2_reg_valid", 64'(rreq.valid), 64'd0);
    cyc(); smp();
    chk("wb_beat3_w_ready", 64'(rsp.w_ready), 64'd1);
    chk("wb_beat3_reg_valid", 64'(rreq.valid), 64'd0);
    cyc();
    req.w.last = 1'b1;
    smp();
    chk("wb_beat4_w_ready", 64'(rsp.w_ready), 64'd1);
    chk("wb_beat4_b_valid", 64'(rsp.b_valid), 64'd0);
    cyc();
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    smp();
    chk("wb_b_valid", 64'(rsp.b_valid), 64'd1);
    chk("wb_b_resp", 64'(rsp.b.resp), 64'd2);
    chk("wb_b_id", 64'(rsp.b.id), 64'd2);
    chk("wb_b_w_ready", 64'(rsp.w_ready), 64'd0);
    chk("wb_b_reg_valid", 64'(rreq.valid), 64'd0);
    cyc();
    req.b_ready = 1'b0;
    smp();
    chk("wb_b_done", 64'(rsp.b_valid), 64'd0);

    // read burst len 2 and size-3 read: SLVERR beats, no register access
    cyc();
    set_ar(4'd6, 64'h40, 8'd2, 3'd2);
    req.ar_valid = 1'b1; req.r_ready = 1'b1;
    smp();
    chk("rb_ar_ready", 64'(rsp.ar_ready), 64'd1);
    cyc();
    req.ar_valid = 1'b0;
    smp();
    chk("rb_beat1_valid", 64'(rsp.r_valid), 64'd1);
    chk("rb_beat1_resp", 64'(rsp.r.resp), 64'd2);
    chk("rb_beat1_last", 64'(rsp.r.last), 64'd0);
    chk("rb_beat1_data", rsp.r.data, 64'd0);
    chk("rb_beat1_reg_valid", 64'(rreq.valid), 64'd0);
    cyc(); smp();
    chk("rb_beat2_valid", 64'(rsp.r_valid), 64'd1);
    chk("rb_beat2_last", 64'(rsp.r.last), 64'd0);
    cyc(); smp();
    chk("rb_beat3_valid", 64'(rsp.r_valid), 64'd1);
    chk("rb_beat3_last", 64'(rsp.r.last), 64'd1);
    chk("rb_beat3_id", 64'(rsp.r.id), 64'd6);
    cyc();
    set_ar(4'd7, 64'h48, 8'd0, 3'd3);
    req.ar_valid = 1'b1;
    smp();
    chk("rs3_idle_r_valid", 64'(rsp.r_valid), 64'd0);
    chk("rs3_ar_ready", 64'(rsp.ar_ready), 64'd1);
    cyc();
    req.ar_valid = 1'b0;
    smp();
    chk("rs3_r_valid", 64'(rsp.r_valid), 64'd1);
    chk("rs3_r_last", 64'(rsp.r.last), 64'd1);
    chk("rs3_r_resp", 64'(rsp.r.resp), 64'd2);
    chk("rs3_r_id", 64'(rsp.r.id), 64'd7);
    chk("rs3_reg_valid", 64'(rreq.valid), 64'd0);
    cyc(); smp();
    chk("rs3_r_done", 64'(rsp.r_valid), 64'd0);

    // timeout: reg valid for exactly 4 cycles, then SLVERR
    cyc();
    rrsp.ready = 1'b0;
    set_aw(4'd4, 64'h10, 8'd0, 3'd2);
    req.aw_valid = 1'b1;
    req.w.data = 64'h00000000_DEADBEEF; req.w.strb = 8'h0F; req.w.last = 1'b1; req.w_valid = 1'b1;
    smp();
    chk("to_aw_ready", 64'(rsp.aw_ready), 64'd1);
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    smp();
    chk("to_valid_c1", 64'(rreq.valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk("to_valid_held", 64'(rreq.valid), 64'd1);
    end
    cyc(); smp();
    chk("to_valid_dropped", 64'(rreq.valid), 64'd0);
    chk("to_b_valid", 64'(rsp.b_valid), 64'd1);
    chk("to_b_resp", 64'(rsp.b.resp), 64'd2);
    cyc();
    req.b_ready = 1'b1;
    smp();
    cyc();
    req.b_ready = 1'b0;

    // ready arriving on the limit cycle wins over the timeout
    set_aw(4'd8, 64'h18, 8'd0, 3'd2);
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    smp();
    chk("rw_aw_ready", 64'(rsp.aw_ready), 64'd1);
    cyc();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    smp();
    cyc(); smp();
    cyc(); smp();
    cyc();
    rrsp.ready = 1'b1; rrsp.error = 1'b0;
    smp();
    chk("rw_valid_c4", 64'(rreq.valid), 64'd1);
    cyc();
    rrsp.ready = 1'b0;
    smp();
    chk("rw_b_valid", 64'(rsp.b_valid), 64'd1);
    chk("rw_b_resp", 64'(rsp.b.resp), 64'd0);
    chk("rw_b_id", 64'(rsp.b.id), 64'd8);
    cyc();
    req.b_ready = 1'b1;
    smp();
    cyc();
    req.b_ready = 1'b0;

    // reset in the middle of a register read
    set_ar(4'd10, 64'h30, 8'd0, 3'd2);
    req.ar_valid = 1'b1;
    smp();
    chk("ra_ar_ready", 64'(rsp.ar_ready), 64'd1);
    cyc();
    req.ar_valid = 1'b0;
    smp();
    chk("ra_reg_valid", 64'(rreq.valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ra_async_reg_valid", 64'(rreq.valid), 64'd0);
    chk("ra_async_r_valid", 64'(rsp.r_valid), 64'd0);
    chk("ra_async_reg_addr", rreq.addr, 64'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("ra_no_r_valid", 64'(rsp.r_valid), 64'd0);
      chk("ra_no_b_valid", 64'(rsp.b_valid), 64'd0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_axi_reg_bridge.md
# periph_axi_reg_bridge

Converts AXI4 transactions arriving on the crossbar's peripheral master port (PERIPH_BUS_IDX, 64-bit AXI) into single 32-bit register-interface accesses for the peripheral register demux (SOC_CTRL, BOOT_ROM, FAST_INTR_CTRL, UART). It handles one transaction at a time and arbitrates between reads and writes. It rejects bursts and 8-byte accesses with SLVERR, and it bounds every register access with a timeout.

## Interface
- axi_req_t, default core_v_mcu_pkg::axi_slv_req_t: AXI request struct type.
- axi_rsp_t, default core_v_mcu_pkg::axi_slv_rsp_t: AXI response struct type.
- reg_req_t, default core_v_mcu_pkg::reg_req_t: register request struct type (64-bit addr, 32-bit data, 4-bit wstrb).
- reg_rsp_t, default core_v_mcu_pkg::reg_rsp_t: register response struct type.
- TimeoutCycles, default 256: cycles of unanswered reg valid before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- axi_req_i  in  axi_req_t  AXI slave-side request.
- axi_rsp_o  out  axi_rsp_t  AXI slave-side response.
- reg_req_o  out  reg_req_t  register request (addr, write, wdata, wstrb, valid).
- reg_rsp_i  in  reg_rsp_t  register response (rdata, error, ready).

## Operation
States:
- IDLE
- WR_DRAIN
- REG_WR
- REG_RD
- B_RESP
- R_RESP
- R_ERR

Transitions and rules:
- **IDLE, arbitration.** A write is eligible when aw_valid and w_valid are both high. A read is eligible when ar_valid is high. If both are eligible, a round-robin priority bit decides; it resets to write and toggles after each granted transaction.
- **Write grant.** aw_ready and w_ready pulse together for one cycle. The bridge latches id, addr, size, len, wdata and wstrb.
  - len==0 and size<=2: go to REG_WR.
  - len!=0 and w_last low: go to WR_DRAIN. WR_DRAIN holds w_ready high until the w_last beat, then goes to B_RESP with SLVERR.
  - len!=0 and w_last high, or size==3: go straight to B_RESP with SLVERR. No register access is made.
- **Read grant.** ar_ready pulses for one cycle. The bridge latches id, addr, size and len.
  - len==0 and size<=2: go to REG_RD.
  - Otherwise: go to R_ERR, which emits len+1 R beats with SLVERR and rdata 0. r_last is set on the final beat.
- **Lane select.** addr[2] selects the half of the 64-bit bus.
  - Write: reg wdata is wdata[63:32] when addr[2]=1, else wdata[31:0]; reg wstrb is taken from the matching wstrb half.
  - A zero wstrb is issued to the register bus unchanged.
  - Read: reg rdata is replicated onto both 32-bit halves of r_data.
- **Register address.** reg addr is the full latched AXI address.
- **REG_WR / REG_RD.** reg valid is high. addr, write, wdata and wstrb stay stable until ready.
  - On ready: resp = error ? SLVERR (2'b10) : OKAY (2'b00). Go to B_RESP or R_RESP.
  - On timeout: drop valid. resp = SLVERR, rdata = 0.
- **B_RESP.** b_valid is held until b_ready; b_id is the latched id. Then return to IDLE.
- **R_RESP.** r_valid and r_last are held until r_ready. Then return to IDLE.
- **User fields.** b_user and r_user are 0.

## Timing
- **Reset values.** All AXI ready and valid outputs and reg valid are 0. State is IDLE and the priority bit is write. The timeout counter, latched fields and resp are 0.
- **Reset during a transaction.** Reset aborts immediately. No B or R response is produced for the aborted transaction.
- **Latency, zero-wait register slave.**
  - Cycle 0: AW/W (or AR) handshake.
  - Cycle 1: reg valid and ready.
  - Cycle 2: b_valid or r_valid.
- **Throughput.** At most one transaction is in flight. The next grant can occur in the cycle after the B or R handshake.
- **Timeout counter.** It resets on entry to REG_*, then increments each cycle that valid=1 and ready=0.
  - When the count reaches TimeoutCycles, the next cycle is B_RESP or R_RESP with SLVERR.
  - If ready arrives in the same cycle the count hits the limit, ready wins.
- **Ready rule.** aw_ready, w_ready and ar_ready are never high outside IDLE, except w_ready in WR_DRAIN. There is no combinational path from reg_rsp_i to any AXI ready.
- **Hold rule.** b_valid and r_valid stay high with stable payload until their ready is sampled high.

## Test plan
- **Single write, upper lane.** AW addr 0x1000_1000_0000_0004, size 2, len 0, id 3; wdata 0xAABBCCDD_11223344, wstrb 0xF0; slave ready in the same cycle. Required: reg wdata 0xAABBCCDD, wstrb 0xF, write=1 on cycle 1; b_valid on cycle 2 with id 3, OKAY.
- **Single read, error slave.** AR addr 0x1000_3000_0000_0000, len 0, id 5; slave returns error=1 with rdata 0x12345678. Required: r_data 0x12345678_12345678, resp SLVERR, r_last=1, id 5.
- **Simultaneous eligibility.** AW/W and AR all valid in the same cycle, twice in a row. Required: the write is granted first, then the read. The priority bit alternates.
- **Write burst rejected.** AW len 3, then four W beats with wlast on the 4th. Required: no reg valid at any point; one B with SLVERR after the 4th W beat.
- **Read burst and size-3 read rejected.** AR len 2 gives 3 R beats with SLVERR, r_last only on beat 3. AR size 3, len 0 gives 1 SLVERR beat. Neither issues a reg access.
- **Timeout and reset abort.** With TimeoutCycles=4 and ready held low: reg valid is high for 4 cycles, then drops, then B SLVERR. Asserting rst_i mid-access clears all valids at once.
